spi_slave_port: RTL and testbench

- SPI target (slave) endpoint, CPHA=0, MSB first, 8-bit frames; the counterpart of the SoC's SPI master.
- External SCLK/CS_N/MOSI are asynchronous. They are synchronized and edge-detected in the `clk` domain.
- CPU side uses the same valid/ready + ctrl-select register handshake as the other SoC peripherals: ctrl=0 status/control, ctrl=1 data.
- Used for board-to-board links and for loopback test against the SoC SPI master.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_port.sv | 159 +++++++++++++++
 tb/tb_spi_slave_port.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state type for spi_slave_port
package spi_pkg;

    localparam int RX_VALID = 0;
    localparam int TX_FULL  = 1;
    localparam int OVERRUN  = 2;
    localparam int UNDERRUN = 3;
    localparam int IE_RX    = 8;
    localparam int IE_TX    = 9;
    localparam int SELECTED = 31;

    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;
    localparam logic [3:0] FRAME_LEN     = 4'd8;

    typedef enum logic {
        ST_IDLE,
        ST_SELECTED
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer plus history FF giving rise/fall pulses
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1, sync2, hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            hist  <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~hist;
    assign fall  = ~sync2 & hist;

endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI target, CPHA=0 MSB first 8-bit frames; irq output under SPI_SLAVE_PORT_IRQ_EN
module spi_slave_port
    import spi_pkg::*;
#(
    parameter logic CPOL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
`ifdef SPI_SLAVE_PORT_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 4'd1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, rx_byte, tx_buf, reload_byte, rx_next;
    logic       rx_valid, tx_full, overrun, underrun;
    logic       lead, trail, rd_pop, wr_tx, wr_ctl;
    logic       ie_rx, ie_tx;

    assign lead        = CPOL ? sclk_fall : sclk_rise;
    assign trail       = CPOL ? sclk_rise : sclk_fall;
    assign rd_pop      = valid && ready && ctrl && (wstrb == 4'b0000);
    assign wr_tx       = valid && ready && ctrl && wstrb[0];
    assign wr_ctl      = valid && ready && !ctrl && wstrb[0];
    assign reload_byte = tx_full ? tx_buf : UNDERRUN_FILL;
    assign rx_next     = {rx_shift[6:0], mosi_lvl};

    // Statement order encodes priority: set beats W1C, completion beats pop, CPU write beats reload clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ready       <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_buf      <= 8'h00;
            tx_full     <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            ie_rx       <= 1'b0;
            ie_tx       <= 1'b0;
        end else begin
            ready <= valid && !ready;
            if (rd_pop) rx_valid <= 1'b0;
            if (wr_ctl) begin
                if (wdata[OVERRUN])  overrun  <= 1'b0;
                if (wdata[UNDERRUN]) underrun <= 1'b0;
`ifdef SPI_SLAVE_PORT_IRQ_EN
                ie_rx <= wdata[IE_RX];
                ie_tx <= wdata[IE_TX];
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state       <= ST_SELECTED;
                        tx_shift    <= reload_byte;
                        spi_miso    <= reload_byte[7];
                        tx_full     <= 1'b0;
                        if (!tx_full) underrun <= 1'b1;
                        bit_cnt     <= 3'd0;
                        rx_shift    <= 8'h00;
                        spi_miso_oe <= 1'b1;
                    end
                end
                ST_SELECTED: begin
                    if (cs_rise) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= 3'd0;
                        rx_shift    <= 8'h00;
                        spi_miso_oe <= 1'b0;
                    end else if (lead) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_byte  <= rx_next;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rd_pop) overrun <= 1'b1;
                        end
                    end else if (trail) begin
                        if (bit_cnt != 3'd0) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            spi_miso <= tx_shift[6];
                        end else begin
                            tx_shift <= reload_byte;
                            spi_miso <= reload_byte[7];
                            tx_full  <= 1'b0;
                            if (!tx_full) underrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (wr_tx) begin
                tx_buf  <= wdata[7:0];
                tx_full <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_PORT_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= (rx_valid & ie_rx) | (!tx_full & ie_tx);
    end
`endif

    always_comb begin
        rdata = 32'h0;
        if (ctrl) begin
            rdata[7:0] = rx_byte;
        end else begin
            rdata[SELECTED] = (state == ST_SELECTED);
            rdata[UNDERRUN] = underrun;
            rdata[OVERRUN]  = overrun;
            rdata[TX_FULL]  = tx_full;
            rdata[RX_VALID] = rx_valid;
`ifdef SPI_SLAVE_PORT_IRQ_EN
            rdata[IE_RX]    = ie_rx;
            rdata[IE_TX]    = ie_tx;
`endif
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - bench for spi_slave_port, CPOL=0 and CPOL=1 instances driven in lockstep
module tb_spi_slave_port;
    logic        clk = 1'b0;
    logic        reset, ctrl, valid;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        phase, cs_n, mosi;
    logic        ready0, ready1, miso0, miso1, oe0, oe1;
    logic [31:0] rdata0, rdata1;
`ifdef SPI_SLAVE_PORT_IRQ_EN
    logic        irq0, irq1;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] rd [2];
    logic [7:0]  got [2];
    logic [7:0]  exp_miso [$];
    logic [7:0]  exp_rx [$];
    logic [7:0]  expb;

    always #5 clk = ~clk;

    spi_slave_port #(.CPOL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .valid(valid), .ready(ready0),
        .wstrb(wstrb), .wdata(wdata), .rdata(rdata0),
        .spi_sclk(phase), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0)
`ifdef SPI_SLAVE_PORT_IRQ_EN
        , .irq(irq0)
`endif
    );

    spi_slave_port #(.CPOL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .valid(valid), .ready(ready1),
        .wstrb(wstrb), .wdata(wdata), .rdata(rdata1),
        .spi_sclk(~phase), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso1), .spi_miso_oe(oe1)
`ifdef SPI_SLAVE_PORT_IRQ_EN
        , .irq(irq1)
`endif
    );

    task automatic cpu(input logic c, input logic [3:0] s, input logic [31:0] d);
        int n;
        @(negedge clk);
        ctrl = c; wstrb = s; wdata = d; valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready0 && n < 8);
        checks++;
        if (!ready0 || !ready1) begin
            errors++;
            $display("FAIL cpu_ready_timeout: ready0=%b ready1=%b want 1", ready0, ready1);
        end
        rd[0] = rdata0;
        rd[1] = rdata1;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0; wdata = 32'h0;
    endtask

    task automatic status_is(input logic [31:0] exp, input string tag);
        cpu(1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd[k] !== exp) begin
                errors++;
                $display("FAIL %s inst%0d: status=%h want %h", tag, k, rd[k], exp);
            end
        end
    endtask

    task automatic read_data(input string tag);
        if (exp_rx.size() == 0) expb = 8'hxx;
        else expb = exp_rx.pop_front();
        cpu(1'b1, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd[k] !== {24'h0, expb}) begin
                errors++;
                $display("FAIL %s inst%0d: data=%h want %h", tag, k, rd[k], {24'h0, expb});
            end
        end
    endtask

    task automatic spi_select();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (oe0 !== 1'b1 || oe1 !== 1'b1) begin
            errors++;
            $display("FAIL oe_on_select: oe0=%b oe1=%b want 1", oe0, oe1);
        end
    endtask

    task automatic spi_deselect();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (oe0 !== 1'b0 || oe1 !== 1'b0) begin
            errors++;
            $display("FAIL oe_on_deselect: oe0=%b oe1=%b want 0", oe0, oe1);
        end
    endtask

    // Master side: drives MOSI, samples MISO on the leading edge; pop_mid lines a data read up with byte completion.
    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit pop_mid);
        got[0] = 8'h0; got[1] = 8'h0;
        mosi = b[7];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            phase = 1'b1;
            got[0] = {got[0][6:0], miso0};
            got[1] = {got[1][6:0], miso1};
            if (pop_mid && i == 7) begin
                @(negedge clk);
                ctrl = 1'b1; wstrb = 4'h0; valid = 1'b1;
                @(negedge clk);
                rd[0] = rdata0; rd[1] = rdata1;
                expb = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'hxx;
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (!ready0 || rd[k] !== {24'h0, expb}) begin
                        errors++;
                        $display("FAIL aligned_pop inst%0d: data=%h ready=%b want %h", k, rd[k], ready0, {24'h0, expb});
                    end
                end
                @(negedge clk);
                valid = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            phase = 1'b0;
            if (i < 7) mosi = b[6-i];
            repeat (4) @(negedge clk);
        end
        if (nbits == 8) begin
            expb = (exp_miso.size() != 0) ? exp_miso.pop_front() : 8'hxx;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== expb) begin
                    errors++;
                    $display("FAIL miso_byte inst%0d: got %h want %h", k, got[k], expb);
                end
            end
            exp_rx.delete();
            exp_rx.push_back(b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready0, ready1, miso0, miso1, oe0, oe1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready/miso/oe=%b want 000000", {ready0, ready1, miso0, miso1, oe0, oe1});
        end
`ifdef SPI_SLAVE_PORT_IRQ_EN
        checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: irq0=%b irq1=%b want 0", irq0, irq1);
        end
`endif
        status_is(32'h0, "reset_status");
        read_data_zero();
    endtask

    task automatic read_data_zero();
        exp_rx.delete();
        exp_rx.push_back(8'h00);
        read_data("reset_data");
    endtask

    task automatic test_basic();
        cpu(1'b1, 4'h1, 32'hA5);
        status_is(32'h2, "basic_tx_full");
        exp_miso.push_back(8'hA5);
        spi_select();
        spi_byte(8'h3C, 8, 1'b0);
        spi_deselect();
        status_is(32'h9, "basic_status");
        read_data("basic_data");
        status_is(32'h8, "basic_popped");
        cpu(1'b0, 4'h1, 32'h8);
        status_is(32'h0, "basic_clear");
    endtask

    task automatic test_underrun();
        exp_miso.push_back(8'hFF);
        spi_select();
        status_is(32'h8000_0008, "underrun_selected");
        spi_byte(8'h00, 8, 1'b0);
        spi_deselect();
        status_is(32'h9, "underrun_status");
        cpu(1'b0, 4'h1, 32'h8);
        status_is(32'h1, "underrun_w1c");
        read_data("underrun_data");
        status_is(32'h0, "underrun_clear");
    endtask

    task automatic test_back_to_back();
        cpu(1'b1, 4'h1, 32'h96);
        exp_miso.push_back(8'h96);
        exp_miso.push_back(8'hFF);
        spi_select();
        spi_byte(8'h11, 8, 1'b0);
        spi_byte(8'h22, 8, 1'b0);
        spi_deselect();
        status_is(32'hD, "b2b_overrun");
        cpu(1'b0, 4'h1, 32'hC);
        status_is(32'h1, "b2b_w1c");
        read_data("b2b_data");
        exp_miso.push_back(8'hFF);
        exp_miso.push_back(8'hFF);
        spi_select();
        spi_byte(8'h11, 8, 1'b0);
        spi_byte(8'h22, 8, 1'b1);
        spi_deselect();
        status_is(32'h9, "b2b_pop_no_overrun");
        cpu(1'b0, 4'h1, 32'h8);
        read_data("b2b_pop_data");
    endtask

    task automatic test_cs_abort();
        spi_select();
        spi_byte(8'hFF, 5, 1'b0);
        spi_deselect();
        status_is(32'h8, "abort_status");
        exp_miso.push_back(8'hFF);
        spi_select();
        spi_byte(8'h81, 8, 1'b0);
        spi_deselect();
        status_is(32'h9, "abort_next_status");
        read_data("abort_next_data");
        cpu(1'b0, 4'h1, 32'h8);
    endtask

    task automatic test_cpol1_reset();
        cpu(1'b1, 4'h1, 32'hC3);
        exp_miso.push_back(8'hC3);
        spi_select();
        spi_byte(8'h5A, 8, 1'b0);
        spi_deselect();
        read_data("xchg_data");
        cpu(1'b0, 4'h1, 32'h8);
        cpu(1'b1, 4'h1, 32'h44);
        spi_select();
        spi_byte(8'h0F, 4, 1'b0);
        reset = 1'b1;
        phase = 1'b0;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({oe0, oe1, miso0, miso1} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_outputs: oe/miso=%b want 0000", {oe0, oe1, miso0, miso1});
        end
        status_is(32'h0, "midreset_status");
        exp_rx.delete();
        cpu(1'b1, 4'h1, 32'hE7);
        exp_miso.push_back(8'hE7);
        spi_select();
        spi_byte(8'h42, 8, 1'b0);
        spi_deselect();
        read_data("midreset_next_data");
        cpu(1'b0, 4'h1, 32'h8);
    endtask

    task automatic test_irq();
`ifdef SPI_SLAVE_PORT_IRQ_EN
        cpu(1'b0, 4'h1, 32'h100);
        status_is(32'h100, "irq_ie_rx");
        checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle: irq0=%b irq1=%b want 0", irq0, irq1);
        end
        exp_miso.push_back(8'hFF);
        spi_select();
        spi_byte(8'h99, 8, 1'b0);
        spi_deselect();
        repeat (2) @(negedge clk);
        checks++;
        if (irq0 !== 1'b1 || irq1 !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: irq0=%b irq1=%b want 1", irq0, irq1);
        end
        read_data("irq_data");
        repeat (2) @(negedge clk);
        checks++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: irq0=%b irq1=%b want 0", irq0, irq1);
        end
        cpu(1'b0, 4'h1, 32'h8);
        status_is(32'h0, "irq_clear");
`else
        cpu(1'b0, 4'h1, 32'h30C);
        status_is(32'h0, "ie_bits_absent");
`endif
    endtask

    initial begin
        reset = 1'b1; ctrl = 1'b0; valid = 1'b0; wstrb = 4'h0; wdata = 32'h0;
        phase = 1'b0; cs_n = 1'b1; mosi = 1'b1;
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_cs_abort();
        test_cpol1_reset();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
